// File: rtl/user_io_conditioner.sv
// rtl/user_io_conditioner.sv - pad synchronizer + per-bit debounce; edge pulses under IOCOND_EDGE_EN
module user_io_conditioner #(
  parameter int WIDTH    = 9,
  parameter int DB_COUNT = 4,
  parameter int PRESCALE = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [WIDTH-1:0] pad_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] pad_oeb_o,
  output logic [WIDTH-1:0] changed_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  DB_LAST = 8'(DB_COUNT - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [15:0]      r_pcnt;
  logic [7:0]       r_cnt [WIDTH];
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_changed;
  logic             w_tick;
  logic [WIDTH-1:0] w_update;

  // Consumed pads are inputs permanently, independent of reset.
  assign pad_oeb_o = '1;
  assign data_o    = r_data;
  assign changed_o = r_changed;
  assign w_tick    = (r_pcnt == PS_LAST);

  // Two-flop synchronizer, nothing between the stages.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pad_i;
      r_s2 <= r_s1;
    end
  end

  // Debounce tick prescaler: counts 0..PRESCALE-1 and wraps.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  // A bit flips when it has differed from data_o for DB_COUNT consecutive ticks.
  always_comb begin
    w_update = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_update[b] = (r_s2[b] != r_data[b]) && w_tick && (r_cnt[b] == DB_LAST);
    end
  end

  // Per-bit qualification counters; any agreement with data_o restarts the count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int b = 0; b < WIDTH; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (r_s2[b] == r_data[b]) begin
          r_cnt[b] <= '0;
        end else if (w_tick) begin
          if (r_cnt[b] == DB_LAST) begin
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + 8'd1;
          end
        end
      end
    end
  end

  // Debounced levels and sticky change flags; a new change beats a clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_data    <= '0;
      r_changed <= '0;
    end else begin
      r_data    <= r_data ^ w_update;
      r_changed <= w_update | (clr_i ? '0 : r_changed);
    end
  end

`ifdef IOCOND_EDGE_EN
  logic [WIDTH-1:0] r_data_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  assign rise_o = r_rise;
  assign fall_o = r_fall;

  // Edge pulses are registered so they appear the cycle after data_o changes.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_data_q <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
    end else begin
      r_data_q <= r_data;
      r_rise   <= r_data & ~r_data_q;
      r_fall   <= ~r_data & r_data_q;
    end
  end
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule
